// File: rtl/conv_stream_engine.sv
// conv_stream_engine: raster-order image stream -> KSIZE x KSIZE sliding window ->
// NUM_KER parallel signed dot products, with ready/valid flow control on both sides.
// Optional feature macro: CONV_RELU_EN (negative kernel results forced to zero).
// Pipeline: accept -> window shift register -> products -> sums -> shift/saturate/output.
module conv_stream_engine #(
   parameter int IMG_COL    = 8,
   parameter int IMG_ROW    = 8,
   parameter int DATA_WIDTH = 16,
   parameter int KSIZE      = 3,
   parameter int NUM_KER    = 4,
   parameter int FRAC_BITS  = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          ker_valid,
   input  logic [DATA_WIDTH-1:0]         ker_data,
   input  logic                          img_valid,
   output logic                          img_ready,
   input  logic [DATA_WIDTH-1:0]         img_data,
   output logic [NUM_KER*DATA_WIDTH-1:0] conv_dout,
   output logic                          conv_ovalid,
   input  logic                          conv_oready,
   output logic                          conv_done,
   output logic                          busy
);

   localparam int KK     = KSIZE * KSIZE;
   localparam int NCOEF  = NUM_KER * KK;
   localparam int PTR_W  = $clog2(NCOEF);
   localparam int COL_W  = $clog2(IMG_COL);
   localparam int ROW_W  = $clog2(IMG_ROW);
   // Newest pixel at index 0; a pixel exactly one image row older sits IMG_COL further on.
   localparam int SR_LEN = (KSIZE - 1) * IMG_COL + KSIZE;
   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam int ACC_W  = PROD_W + $clog2(KK);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NCOEF - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COL - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROW - 1);
   localparam logic [COL_W-1:0] COL_WIN  = COL_W'(KSIZE - 1);
   localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(KSIZE - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t state_reg, state_next;

   logic signed [DATA_WIDTH-1:0] coef_reg [NCOEF];
   logic [PTR_W-1:0]             ptr_reg;
   logic [ROW_W-1:0]             row_reg;
   logic [COL_W-1:0]             col_reg;
   logic signed [DATA_WIDTH-1:0] sr_reg [SR_LEN];

   logic signed [PROD_W-1:0]     prod_w   [NCOEF];
   logic signed [PROD_W-1:0]     prod_reg [NCOEF];
   logic signed [ACC_W-1:0]      sum_w    [NUM_KER];
   logic signed [ACC_W-1:0]      sum_reg  [NUM_KER];
   logic [NUM_KER*DATA_WIDTH-1:0] res_w;
   logic signed [ACC_W-1:0]      shifted;
   logic [DATA_WIDTH-1:0]        lane;

   logic v0_reg, v1_reg, v2_reg;
   logic pipe_en, accept, win_ok, last_pix;

   // The whole pipeline freezes only when a finished result is waiting on downstream.
   assign pipe_en  = !(conv_ovalid && !conv_oready);
   assign accept   = img_valid && pipe_en && (state_reg == S_RUN);
   assign win_ok   = (row_reg >= ROW_WIN) && (col_reg >= COL_WIN);
   assign last_pix = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic and state-decoded handshake/status outputs.
   always_comb begin
      state_next = state_reg;
      img_ready  = 1'b0;
      busy       = 1'b0;
      conv_done  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) state_next = S_RUN;
         end
         S_RUN: begin
            busy      = 1'b1;
            img_ready = pipe_en;
            if (accept && last_pix) state_next = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            // Leave once nothing is in flight and the final result is leaving this cycle.
            if (!v0_reg && !v1_reg && !v2_reg && (!conv_ovalid || conv_oready))
               state_next = S_DONE;
         end
         S_DONE: begin
            conv_done  = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Coefficient write pointer: advances per IDLE write, wraps, and rewinds on start.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg <= '0;
      end else if (state_reg == S_IDLE) begin
         if (start)
            ptr_reg <= '0;
         else if (ker_valid)
            ptr_reg <= (ptr_reg == PTR_LAST) ? '0 : ptr_reg + PTR_W'(1);
      end
   end

   // Coefficient storage; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (!rst && state_reg == S_IDLE && ker_valid)
         coef_reg[ptr_reg] <= ker_data;
   end

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clk) begin
      if (rst || (state_reg == S_IDLE && start)) begin
         row_reg <= '0;
         col_reg <= '0;
      end else if (accept) begin
         if (col_reg == COL_LAST) begin
            col_reg <= '0;
            row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
         end else begin
            col_reg <= col_reg + COL_W'(1);
         end
      end
   end

   // Line buffer plus window as one shift chain, advanced only by accepted pixels.
   always_ff @(posedge clk) begin
      if (accept) begin
         sr_reg[0] <= img_data;
         for (int i = 1; i < SR_LEN; i++)
            sr_reg[i] <= sr_reg[i-1];
      end
   end

   // Window tap (row wr, col wc) of kernel gi times its coefficient.
   generate
      for (genvar gi = 0; gi < NUM_KER; gi++) begin : g_ker
         for (genvar gj = 0; gj < KK; gj++) begin : g_tap
            localparam int WR  = gj / KSIZE;
            localparam int WC  = gj % KSIZE;
            localparam int TAP = (KSIZE - 1 - WR) * IMG_COL + (KSIZE - 1 - WC);
            assign prod_w[gi*KK+gj] = PROD_W'(coef_reg[gi*KK+gj]) * PROD_W'(sr_reg[TAP]);
         end
      end
   endgenerate

   // Per-kernel sum of sign-extended products; the accumulator is wide enough never to wrap.
   always_comb begin
      for (int k = 0; k < NUM_KER; k++) begin
         sum_w[k] = '0;
         for (int t = 0; t < KK; t++)
            sum_w[k] = sum_w[k] +
               {{(ACC_W-PROD_W){prod_reg[k*KK+t][PROD_W-1]}}, prod_reg[k*KK+t]};
      end
   end

   // Scale, saturate to the output width and optionally clamp negatives.
   always_comb begin
      res_w   = '0;
      shifted = '0;
      lane    = '0;
      for (int k = 0; k < NUM_KER; k++) begin
         shifted = sum_reg[k] >>> FRAC_BITS;
         if (shifted > SAT_MAX)
            lane = SAT_MAX[DATA_WIDTH-1:0];
         else if (shifted < SAT_MIN)
            lane = SAT_MIN[DATA_WIDTH-1:0];
         else
            lane = shifted[DATA_WIDTH-1:0];
`ifdef CONV_RELU_EN
         if (lane[DATA_WIDTH-1])
            lane = '0;
`endif
         res_w[k*DATA_WIDTH +: DATA_WIDTH] = lane;
      end
   end

   // Product and sum data stages; they carry no reset since valid bits qualify them.
   always_ff @(posedge clk) begin
      if (pipe_en) begin
         for (int t = 0; t < NCOEF; t++)
            prod_reg[t] <= prod_w[t];
         for (int k = 0; k < NUM_KER; k++)
            sum_reg[k] <= sum_w[k];
      end
   end

   // Valid bits and output register; row-wrap windows and bubbles never set v0.
   always_ff @(posedge clk) begin
      if (rst) begin
         v0_reg      <= 1'b0;
         v1_reg      <= 1'b0;
         v2_reg      <= 1'b0;
         conv_ovalid <= 1'b0;
         conv_dout   <= '0;
      end else if (pipe_en) begin
         v0_reg      <= accept && win_ok;
         v1_reg      <= v0_reg;
         v2_reg      <= v1_reg;
         conv_ovalid <= v2_reg;
         if (v2_reg)
            conv_dout <= res_w;
      end
   end

endmodule
